// File: rtl/silpa_regs_pkg.sv
// Shared register-map constants for the SPI-attached slot I/O block.
// Address windows are 8 entries wide, so addr[7:3] names the window and addr[2:0] the slot.
package silpa_regs_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int SLOTS  = 8;

  localparam logic [ADDR_W-1:0] ADDR_IN_BASE       = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_DIR_BASE      = 8'h10;
  localparam logic [ADDR_W-1:0] ADDR_INT_MASK_BASE = 8'h20;
  localparam logic [ADDR_W-1:0] ADDR_INT_CLR_BASE  = 8'h28;

  typedef enum logic [4:0] {
    WIN_MASK = ADDR_INT_MASK_BASE[ADDR_W-1:3],
    WIN_PEND = ADDR_INT_CLR_BASE[ADDR_W-1:3]
  } win_e;

  function automatic logic [4:0] win_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:3];
  endfunction

  function automatic logic [2:0] slot_of(input logic [ADDR_W-1:0] addr);
    return addr[2:0];
  endfunction

endpackage

// File: rtl/slot_irq_ctrl_bus_sync.sv
// Multi-flop synchronizer for one slot's worth of asynchronous pins.
// Every bit is synchronized independently; the bus is not treated as a coherent word.
module bus_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_r [STAGES];

  // Shift the raw pins through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_r[i] <= '0;
      end
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/slot_irq_ctrl.sv
// Per-slot interrupt controller: synchronizes slot pins, latches unmasked edges into sticky
// pending bits, and serves the mask (0x20-0x27) and W1C pending (0x28-0x2F) register windows.
module slot_irq_ctrl #(
  parameter int SLOTS       = silpa_regs_pkg::SLOTS,
  parameter int DATA_W      = silpa_regs_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [SLOTS*DATA_W-1:0]  slot_in,
  input  logic                     wr_en,
  input  logic [7:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [7:0]               rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_hit,
  output logic [SLOTS*DATA_W-1:0]  slot_sync,
  output logic                     irq
);

  import silpa_regs_pkg::*;

  logic [DATA_W-1:0] sync_s     [SLOTS];
  logic [DATA_W-1:0] edge_s     [SLOTS];
  logic [DATA_W-1:0] mask_nxt_s [SLOTS];
  logic [DATA_W-1:0] pend_nxt_s [SLOTS];
  logic [DATA_W-1:0] prev_r     [SLOTS];
  logic [DATA_W-1:0] mask_r     [SLOTS];
  logic [DATA_W-1:0] pend_r     [SLOTS];

  logic [SLOTS-1:0]  wr_mask_sel_s;
  logic [SLOTS-1:0]  wr_pend_sel_s;
  logic              any_pend_s;
  logic              rd_hit_s;
  logic [DATA_W-1:0] rd_val_s;

  logic [DATA_W-1:0] rd_data_r;
  logic              rd_hit_r;
  logic              irq_r;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    bus_sync #(
      .WIDTH  (DATA_W),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (slot_in[g*DATA_W +: DATA_W]),
      .q     (sync_s[g])
    );

    assign slot_sync[g*DATA_W +: DATA_W] = sync_s[g];
    assign edge_s[g] = sync_s[g] ^ prev_r[g];
    assign wr_mask_sel_s[g] = wr_en & (win_of(wr_addr) == WIN_MASK) & (slot_of(wr_addr) == 3'(g));
    assign wr_pend_sel_s[g] = wr_en & (win_of(wr_addr) == WIN_PEND) & (slot_of(wr_addr) == 3'(g));
  end

  // Next-state for mask and pending; the set term is OR'd last so a same-cycle clear loses.
  always_comb begin
    any_pend_s = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (wr_mask_sel_s[s]) begin
        mask_nxt_s[s] = wr_data;
      end else begin
        mask_nxt_s[s] = mask_r[s];
      end
      if (wr_pend_sel_s[s]) begin
        pend_nxt_s[s] = (pend_r[s] & ~wr_data) | (edge_s[s] & mask_r[s]);
      end else begin
        pend_nxt_s[s] = pend_r[s] | (edge_s[s] & mask_r[s]);
      end
      any_pend_s = any_pend_s | (|pend_r[s]);
    end
  end

  // Read mux over the two windows; anything else reads as a miss with zero data.
  always_comb begin
    rd_hit_s = 1'b0;
    rd_val_s = '0;
    case (win_of(rd_addr))
      WIN_MASK: begin
        rd_hit_s = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
          rd_val_s |= (slot_of(rd_addr) == 3'(s)) ? mask_r[s] : '0;
        end
      end
      WIN_PEND: begin
        rd_hit_s = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
          rd_val_s |= (slot_of(rd_addr) == 3'(s)) ? pend_r[s] : '0;
        end
      end
      default: begin
        rd_hit_s = 1'b0;
        rd_val_s = '0;
      end
    endcase
  end

  // Register state, the aggregated interrupt and the held read response.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        prev_r[s] <= '0;
        mask_r[s] <= '0;
        pend_r[s] <= '0;
      end
      rd_data_r <= '0;
      rd_hit_r  <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        prev_r[s] <= sync_s[s];
        mask_r[s] <= mask_nxt_s[s];
        pend_r[s] <= pend_nxt_s[s];
      end
      irq_r <= any_pend_s;
      if (rd_en) begin
        rd_data_r <= rd_val_s;
        rd_hit_r  <= rd_hit_s;
      end else begin
        rd_data_r <= rd_data_r;
        rd_hit_r  <= rd_hit_r;
      end
    end
  end

  assign rd_data = rd_data_r;
  assign rd_hit  = rd_hit_r;
  assign irq     = irq_r;

endmodule

// File: doc/slot_irq_ctrl.md
# slot_irq_ctrl

Per-slot interrupt controller downstream of the SPI register decoder. Synchronizes the raw slot input pins, detects edges on unmasked bits, and latches them in sticky pending registers. Drives one aggregated interrupt line, the board `user_led` interrupt output. Serves the interrupt-mask (0x20–0x27) and interrupt-clear/pending (0x28–0x2F) register windows of the 8-bit-address / 16-bit-data SPI map.

## Interface
- `SLOTS`, 8: number of 16-bit slots.
- `DATA_W`, 16: bits per slot.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer (minimum 2).
- `sys_clk`, in, 1: system clock; all logic in this domain.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `slot_in`, in, SLOTS*DATA_W: raw asynchronous slot pins; slot s occupies bits [s*DATA_W +: DATA_W].
- `wr_en`, in, 1: single-cycle write strobe from the SPI decoder.
- `wr_addr`, in, 8: write address.
- `wr_data`, in, DATA_W: write data.
- `rd_en`, in, 1: single-cycle read strobe.
- `rd_addr`, in, 8: read address.
- `rd_data`, out, DATA_W: read data, registered.
- `rd_hit`, out, 1: registered; high when the read address fell in this block's window.
- `slot_sync`, out, SLOTS*DATA_W: synchronized slot inputs, for the input-read registers 0x08–0x0F.
- `irq`, out, 1: aggregated interrupt, registered, active-high.

## Operation
- **Mask registers:** `mask[s]` at 0x20+s.
  - Write replaces the register.
  - Read returns the current value.
- **Pending registers:** `pend[s]` at 0x28+s.
  - Write is write-one-to-clear: `pend[s] <= pend[s] & ~wr_data`.
  - Read returns pending.
- Addresses outside 0x20–0x2F are ignored for writes. On reads they give `rd_hit`=0 and `rd_data`=0.
- Address decode: `wr_addr[7:3]` selects the window (0x04 mask, 0x05 pending); `wr_addr[2:0]` selects the slot.
- **Edge detection:** `edge[s] = slot_sync[s] ^ prev[s]`, where `prev` is `slot_sync` delayed one cycle. Both rising and falling edges count.
- **Set rule:** `pend[s]` bit b sets when `edge[s][b] & mask[s][b]` in that cycle. An edge on a masked-off bit is discarded; it is not latched for later unmasking.
- **Simultaneous set and clear** of the same bit in the same cycle: set wins, so the bit stays 1.
- Writing the mask never alters pending. Clearing a mask bit leaves an already-pending bit pending.
- `irq <= |pend` (OR over all slots and bits).
- **Reset values:**
  - `mask`, `pend`, `prev`, synchronizer flops: 0.
  - `rd_data`=0, `rd_hit`=0, `irq`=0.
- **First cycles after reset:** `prev` and the synchronizer start at 0, so a pin held high at reset release produces one rising edge. If the mask is 0 at that point (it is after reset), the edge is discarded.
- **Reset mid-operation:** all state returns asynchronously to the reset values. A read in flight is lost (`rd_hit`=0).

## Timing
- **Pin to `slot_sync`:** SYNC_STAGES cycles.
- **Pin to `pend` set:** SYNC_STAGES+1 cycles. `prev` compare is combinational; `pend` is registered.
- **Pin to `irq` high:** SYNC_STAGES+2 cycles (4 at default).
- **Clear write:** with `wr_en` at cycle N, `pend` clears at N+1 and `irq` falls at N+2, provided no other bits are pending.
- **Reads:** `rd_en` at cycle N gives `rd_data`/`rd_hit` at N+1 and held until the next `rd_en`.
  - Data reflects register state at cycle N.
  - A read and a write to the same register in the same cycle return the pre-write value.
- Strobes are single-cycle. A strobe held high for k cycles acts as k accesses, which is idempotent for both register types.
- Pulses on `slot_in` shorter than one `sys_clk` period may be missed. The SPI master must not rely on them.

## Structure
Shared package `silpa_regs_pkg`:
- `ADDR_W`=8 and `DATA_W`=16.
- `ADDR_IN_BASE`=0x08, `ADDR_DIR_BASE`=0x10, `ADDR_INT_MASK_BASE`=0x20, `ADDR_INT_CLR_BASE`=0x28.
- `SLOTS`=8.

One sub-module, `bus_sync`: a DATA_W-wide, SYNC_STAGES-deep flop chain with async active-low reset, instantiated once per slot. The rest is flat in `slot_irq_ctrl`.

## Test plan
- **Reset:** assert `sys_rst_n`=0 mid-run with pending set → `irq`=0 and all `rd_data` reads 0x0000 after release; slot 0 pins held at 0xFFFF at release with mask 0 → `pend[0]`=0.
- **Unmasked edge:** write 0x20←0xFFFF, toggle `slot_in[0]` bit 0 0→1 → `irq` high exactly 4 cycles later; read 0x28 → 0x0001, `rd_hit`=1.
- **Masked-off bit:** mask[3]=0x00F0, toggle slot 3 bits 0 and 4 → read 0x2B returns 0x0010; then set mask[3]=0xFFFF → still 0x0010.
- **W1C:** pend[0]=0x0003, write 0x28←0x0001 → read 0x0002, `irq` stays 1; write 0x28←0x0002 → `irq`=0 two cycles after the strobe.
- **Set-wins collision:** time a falling edge on slot 5 bit 7 to the same cycle as write 0x2D←0x0080 → `pend[5]`=0x0080, `irq`=1.
- **Decode:** write 0x30←0xFFFF and read 0x1F → no state change, `rd_hit`=0, `rd_data`=0x0000; read 0x27 after writing 0xA5A5 → 0xA5A5 one cycle after `rd_en`.
